// File: rtl/ccip_rd_dma_pkg.sv
// ccip_rd_dma_pkg
//   Shared types for the host-memory read engine: a minimal CCI-P channel
//   subset (Tx c0 request and Rx c0 response), the engine state enum, line and
//   address widths, and a helper that builds the reorder-buffer index carried
//   in mdata.
//   Optional build macro used by the top: CCIP_RD_DMA_PERF_EN.
package ccip_rd_dma_pkg;

    localparam int LINE_W  = 512;
    localparam int ADDR_W  = 42;
    localparam int MDATA_W = 16;

    typedef logic [ADDR_W-1:0]  t_ccip_clAddr;
    typedef logic [LINE_W-1:0]  t_ccip_clData;
    typedef logic [MDATA_W-1:0] t_ccip_mdata;

    typedef enum logic [1:0] {
        eVC_VA  = 2'h0,
        eVC_VL0 = 2'h1,
        eVC_VH0 = 2'h2,
        eVC_VH1 = 2'h3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
    } t_if_ccip_Rx;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } t_rd_dma_state;

    // Keep only the low idx_w bits of a request sequence number; that is the
    // reorder-buffer slot the response will come back tagged with.
    function automatic t_ccip_mdata rob_mdata(input t_ccip_mdata seq, input int idx_w);
        t_ccip_mdata mask;
        mask = (MDATA_W'(1) << idx_w) - MDATA_W'(1);
        return seq & mask;
    endfunction

endpackage

// File: rtl/ccip_rd_dma_rob.sv
// ccip_rd_dma_rob
//   Reorder buffer: DEPTH cache lines plus a valid bit per slot.
//   Ports:
//     clk, rst          clock, synchronous active-high reset (clears valid bits)
//     wr_en/wr_idx/wr_data   store a line into a slot; slot valid next cycle
//     rd_idx            head slot to present
//     pop               clear the head slot's valid bit
//     rd_valid/rd_data  head slot contents (registered storage, combinational select)
module ccip_rd_dma_rob
    import ccip_rd_dma_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [LINE_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic              pop,
    output logic              rd_valid,
    output logic [LINE_W-1:0] rd_data
);

    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [LINE_W-1:0] data_d [DEPTH];

    // Pop is applied before the write so a pop and a fill of another slot in
    // the same cycle both land.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (pop) begin
            vld_d[rd_idx] = 1'b0;
        end
        if (wr_en) begin
            vld_d[wr_idx]  = 1'b1;
            data_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Line storage needs no reset: a slot is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign rd_valid = vld_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/ccip_rd_dma.sv
// ccip_rd_dma
//   Host-memory read engine. On start it issues num_lines single-line
//   RDLINE_I reads on CCI-P Tx c0 from base_addr upward, gathers the
//   (possibly out-of-order) Rx c0 responses in a reorder buffer and streams
//   the lines out in address order on a valid/ready port.
//   Ports:
//     clk, rst               clock, synchronous active-high reset
//     rx                     CCI-P Rx (c0TxAlmFull, c0.rspValid/hdr/data used)
//     tx_c0                  registered CCI-P Tx c0 read requests
//     start/base_addr/num_lines   transfer request, sampled on accepted start
//     out_valid/out_ready/out_data  in-order line stream
//     busy, done             status
//     perf_cycles, perf_stall  only with CCIP_RD_DMA_PERF_EN defined
//
//   state | meaning
//   IDLE  | after reset, nothing in flight
//   ISSUE | sending read requests, collecting and delivering lines
//   DRAIN | all requests sent, delivering remaining lines
//   DONE  | every line delivered; waits for the next start
module ccip_rd_dma
    import ccip_rd_dma_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 16,
    parameter int LEN_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  t_if_ccip_Rx       rx,
    output t_if_ccip_c0_Tx    tx_c0,
    input  logic              start,
    input  t_ccip_clAddr      base_addr,
    input  logic [LEN_W-1:0]  num_lines,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LINE_W-1:0] out_data,
    output logic              busy,
    output logic              done
`ifdef CCIP_RD_DMA_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall
`endif
);

    localparam int IDX_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = LEN_W + 1;

    t_rd_dma_state     state_q, state_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  delivered_q, delivered_d;
    logic [LEN_W-1:0]  len_q, len_d;
    t_ccip_clAddr      base_q, base_d;
    t_if_ccip_c0_Tx    tx_q, tx_d;

    logic              start_acc;
    logic              pop;
    logic              rsp_acc;
    logic              issue_en;
    logic [LEN_W-1:0]  cur_len;
    t_ccip_clAddr      cur_base;
    logic [CNT_W-1:0]  cur_issued;
    logic [CNT_W-1:0]  cur_delivered;
    logic [CNT_W-1:0]  in_flight;

    assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
    assign pop       = out_valid && out_ready;
    assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign rsp_acc   = rx.c0.rspValid && (rx.c0.hdr.resp_type == eRSP_RDLINE) && busy;
    assign tx_c0     = tx_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        base_d     = base_q;
        tx_d.valid = 1'b0;
        tx_d.hdr   = tx_q.hdr;

        // The start cycle already counts as an issue slot, so the first request
        // works from the incoming parameters and zeroed counters.
        if (start_acc) begin
            cur_len       = num_lines;
            cur_base      = base_addr;
            cur_issued    = '0;
            cur_delivered = '0;
            len_d         = num_lines;
            base_d        = base_addr;
        end else begin
            cur_len       = len_q;
            cur_base      = base_q;
            cur_issued    = issued_q;
            cur_delivered = delivered_q;
        end

        in_flight = cur_issued - cur_delivered;
        issue_en  = (start_acc || (state_q == ISSUE))
                    && (cur_issued != {1'b0, cur_len})
                    && !rx.c0TxAlmFull
                    && (in_flight < CNT_W'(MAX_OUTSTANDING));

        if (issue_en) begin
            tx_d.valid        = 1'b1;
            tx_d.hdr          = '0;
            tx_d.hdr.vc_sel   = eVC_VA;
            tx_d.hdr.cl_len   = eCL_LEN_1;
            tx_d.hdr.req_type = eREQ_RDLINE_I;
            tx_d.hdr.address  = cur_base + ADDR_W'(cur_issued);
            tx_d.hdr.mdata    = rob_mdata(MDATA_W'(cur_issued), IDX_W);
        end

        issued_d    = cur_issued + CNT_W'(issue_en);
        delivered_d = cur_delivered + CNT_W'(pop);

        case (state_q)
            IDLE, DONE: begin
                if (start_acc) begin
                    if (num_lines == '0) begin
                        state_d = DONE;
                    end else if (issued_d == {1'b0, num_lines}) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issued_d == {1'b0, len_q}) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (delivered_d == {1'b0, len_q}) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            issued_q    <= '0;
            delivered_q <= '0;
            len_q       <= '0;
            base_q      <= '0;
            tx_q        <= '0;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            len_q       <= len_d;
            base_q      <= base_d;
            tx_q        <= tx_d;
        end
    end

    ccip_rd_dma_rob #(
        .DEPTH (MAX_OUTSTANDING),
        .IDX_W (IDX_W)
    ) u_rob (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (rsp_acc),
        .wr_idx   (rx.c0.hdr.mdata[IDX_W-1:0]),
        .wr_data  (rx.c0.data),
        .rd_idx   (delivered_q[IDX_W-1:0]),
        .pop      (pop),
        .rd_valid (out_valid),
        .rd_data  (out_data)
    );

    // Rx fields this engine does not look at.
    logic unused_rx_bits;
    assign unused_rx_bits = ^{rx.c1TxAlmFull, rx.c0.mmioRdValid, rx.c0.mmioWrValid,
                              rx.c0.hdr.vc_used, rx.c0.hdr.rsvd1, rx.c0.hdr.hit_miss,
                              rx.c0.hdr.rsvd0, rx.c0.hdr.cl_num,
                              rx.c0.hdr.mdata[MDATA_W-1:IDX_W]};

`ifdef CCIP_RD_DMA_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stall_d  = perf_stall_q;
        if (start_acc) begin
            perf_cycles_d = '0;
            perf_stall_d  = '0;
        end else begin
            if (busy && (perf_cycles_q != '1)) begin
                perf_cycles_d = perf_cycles_q + 32'd1;
            end
            // A stall only counts while there is still something left to issue.
            if ((state_q == ISSUE) && rx.c0TxAlmFull && (issued_q != {1'b0, len_q})
                && (perf_stall_q != '1)) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_ccip_rd_dma.sv
// tb_ccip_rd_dma
//   Directed bench for ccip_rd_dma (default build, MAX_OUTSTANDING=16).
//   Requests and delivered lines are logged on the falling edge; line data is
//   a fixed function of the line address so order and content can be checked.
module tb_ccip_rd_dma;
    import ccip_rd_dma_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    t_if_ccip_Rx    rx;
    t_if_ccip_c0_Tx tx_c0;
    logic           start;
    t_ccip_clAddr   base_addr;
    logic [15:0]    num_lines;
    logic           out_valid;
    logic           out_ready;
    logic [511:0]   out_data;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        t_ccip_c0_ReqMemHdr hdr;
        int                 cyc;
    } req_t;

    req_t         req_log[$];
    req_t         pend[$];
    logic [511:0] out_log[$];

    ccip_rd_dma dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .tx_c0     (tx_c0),
        .start     (start),
        .base_addr (base_addr),
        .num_lines (num_lines),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : mon
        req_t r;
        if (tx_c0.valid) begin
            r.hdr = tx_c0.hdr;
            r.cyc = cyc;
            req_log.push_back(r);
            pend.push_back(r);
        end
        if (out_valid && out_ready) begin
            out_log.push_back(out_data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [511:0] line_data(input t_ccip_clAddr a);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) begin
            d[i*32 +: 32] = (a[31:0] + 32'(i) * 32'h0101_0101) ^ 32'h5A00_0000;
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input t_ccip_clAddr b, input int n);
        base_addr = b;
        num_lines = 16'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_rsp(input req_t r, input t_ccip_c0_rsp kind);
        rx.c0.rspValid       = 1'b1;
        rx.c0.hdr.mdata      = r.hdr.mdata;
        rx.c0.hdr.resp_type  = kind;
        rx.c0.data           = line_data(r.hdr.address);
        tick();
        rx.c0.rspValid       = 1'b0;
    endtask

    task automatic run_to_done(input int max, input string tag);
        int n = 0;
        while (!done && n < max) begin
            if (pend.size() > 0) send_rsp(pend.pop_front(), eRSP_RDLINE);
            else tick();
            n++;
        end
        chk(tag, 512'(done), 512'(1));
    endtask

    task automatic wait_reqs(input int k, input int max, input string tag);
        int n = 0;
        while (req_log.size() < k && n < max) begin
            tick();
            n++;
        end
        chk(tag, 512'(req_log.size()), 512'(k));
    endtask

    task automatic clear_logs();
        req_log.delete();
        pend.delete();
        out_log.delete();
    endtask

    initial begin : main
        req_t r [4];
        req_t stale [$];

        rst       = 1'b1;
        rx        = '0;
        start     = 1'b0;
        base_addr = '0;
        num_lines = '0;
        out_ready = 1'b0;
        repeat (3) tick();

        chk("rst_tx_valid", 512'(tx_c0.valid), 512'(0));
        chk("rst_tx_hdr", 512'(tx_c0.hdr), 512'(0));
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        rst = 1'b0;
        tick();

        // 1: in-order responses, consumer always ready
        clear_logs();
        out_ready = 1'b1;
        do_start(42'h100, 4);
        chk("t1_first_req_latency", 512'(tx_c0.valid), 512'(1));
        chk("t1_busy", 512'(busy), 512'(1));
        run_to_done(60, "t1_done");
        chk("t1_req_count", 512'(req_log.size()), 512'(4));
        for (int i = 0; i < req_log.size(); i++) begin
            chk("t1_addr", 512'(req_log[i].hdr.address), 512'(42'h100 + 42'(i)));
            chk("t1_mdata", 512'(req_log[i].hdr.mdata), 512'(i));
            chk("t1_b2b", 512'(req_log[i].cyc - req_log[0].cyc), 512'(i));
        end
        if (req_log.size() > 0) begin
            chk("t1_req_type", 512'(req_log[0].hdr.req_type), 512'(eREQ_RDLINE_I));
            chk("t1_cl_len", 512'(req_log[0].hdr.cl_len), 512'(eCL_LEN_1));
            chk("t1_vc_sel", 512'(req_log[0].hdr.vc_sel), 512'(eVC_VA));
        end
        chk("t1_out_count", 512'(out_log.size()), 512'(4));
        for (int i = 0; i < out_log.size(); i++) begin
            chk("t1_out_data", out_log[i], line_data(42'h100 + 42'(i)));
        end
        chk("t1_busy_after", 512'(busy), 512'(0));

        // 2: responses out of order 3,1,0,2
        clear_logs();
        out_ready = 1'b0;
        do_start(42'h200, 4);
        wait_reqs(4, 20, "t2_reqs");
        for (int i = 0; i < 4; i++) r[i] = pend.pop_front();
        send_rsp(r[3], eRSP_RDLINE);
        chk("t2_hold_after_3", 512'(out_valid), 512'(0));
        send_rsp(r[1], eRSP_RDLINE);
        chk("t2_hold_after_1", 512'(out_valid), 512'(0));
        send_rsp(r[0], eRSP_UMSG);
        chk("t2_umsg_ignored", 512'(out_valid), 512'(0));
        send_rsp(r[0], eRSP_RDLINE);
        chk("t2_head_arrived", 512'(out_valid), 512'(1));
        chk("t2_head_data", out_data, line_data(42'h200));
        out_ready = 1'b1;
        send_rsp(r[2], eRSP_RDLINE);
        run_to_done(20, "t2_done");
        chk("t2_out_count", 512'(out_log.size()), 512'(4));
        for (int i = 0; i < out_log.size(); i++) begin
            chk("t2_out_order", out_log[i], line_data(42'h200 + 42'(i)));
        end

        // 3: window limit with a stalled consumer
        clear_logs();
        out_ready = 1'b0;
        do_start(42'h1000, 40);
        repeat (25) tick();
        chk("t3_window_full", 512'(req_log.size()), 512'(16));
        chk("t3_busy", 512'(busy), 512'(1));
        while (pend.size() > 0) send_rsp(pend.pop_front(), eRSP_RDLINE);
        repeat (5) tick();
        chk("t3_still_16", 512'(req_log.size()), 512'(16));
        chk("t3_head_valid", 512'(out_valid), 512'(1));
        out_ready = 1'b1;
        run_to_done(400, "t3_done");
        chk("t3_req_count", 512'(req_log.size()), 512'(40));
        chk("t3_out_count", 512'(out_log.size()), 512'(40));
        for (int i = 0; i < req_log.size(); i++) begin
            chk("t3_addr", 512'(req_log[i].hdr.address), 512'(42'h1000 + 42'(i)));
        end
        for (int i = 0; i < out_log.size(); i++) begin
            chk("t3_out_data", out_log[i], line_data(42'h1000 + 42'(i)));
        end

        // 4: almost-full back-pressure for 5 cycles mid-issue
        clear_logs();
        out_ready = 1'b1;
        do_start(42'h300, 8);
        tick();
        rx.c0TxAlmFull = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_almfull_quiet", 512'(tx_c0.valid), 512'(0));
        end
        rx.c0TxAlmFull = 1'b0;
        run_to_done(100, "t4_done");
        chk("t4_req_count", 512'(req_log.size()), 512'(8));
        for (int i = 0; i < req_log.size(); i++) begin
            chk("t4_addr", 512'(req_log[i].hdr.address), 512'(42'h300 + 42'(i)));
            chk("t4_mdata", 512'(req_log[i].hdr.mdata), 512'(i));
        end
        if (req_log.size() > 2) begin
            chk("t4_gap", 512'(req_log[2].cyc - req_log[1].cyc), 512'(6));
        end
        chk("t4_out_count", 512'(out_log.size()), 512'(8));
        for (int i = 0; i < out_log.size(); i++) begin
            chk("t4_out_data", out_log[i], line_data(42'h300 + 42'(i)));
        end

        // 5: zero-length transfer, then start while busy
        clear_logs();
        do_start(42'h700, 0);
        chk("t5_done_next", 512'(done), 512'(1));
        chk("t5_not_busy", 512'(busy), 512'(0));
        chk("t5_no_tx", 512'(tx_c0.valid), 512'(0));
        repeat (3) tick();
        chk("t5_no_reqs", 512'(req_log.size()), 512'(0));
        out_ready = 1'b1;
        do_start(42'h400, 4);
        chk("t5_busy", 512'(busy), 512'(1));
        chk("t5_done_cleared", 512'(done), 512'(0));
        do_start(42'h900, 2);
        run_to_done(60, "t5_done");
        chk("t5_req_count", 512'(req_log.size()), 512'(4));
        if (req_log.size() > 3) begin
            chk("t5_last_addr", 512'(req_log[3].hdr.address), 512'(42'h403));
        end
        chk("t5_out_count", 512'(out_log.size()), 512'(4));
        if (out_log.size() > 3) begin
            chk("t5_last_data", out_log[3], line_data(42'h403));
        end

        // 6: reset mid-transfer, stale responses, then a fresh transfer
        clear_logs();
        out_ready = 1'b0;
        do_start(42'h500, 8);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_tx", 512'(tx_c0.valid), 512'(0));
        chk("t6_rst_busy", 512'(busy), 512'(0));
        chk("t6_rst_done", 512'(done), 512'(0));
        @(negedge clk);
        chk("t6_issued_before_rst", 512'(req_log.size()), 512'(3));
        stale = pend;
        pend.delete();
        while (stale.size() > 0) send_rsp(stale.pop_front(), eRSP_RDLINE);
        tick();
        chk("t6_stale_dropped", 512'(out_valid), 512'(0));
        clear_logs();
        do_start(42'h600, 2);
        chk("t6_no_stale_after_start", 512'(out_valid), 512'(0));
        out_ready = 1'b1;
        run_to_done(40, "t6_done");
        chk("t6_out_count", 512'(out_log.size()), 512'(2));
        for (int i = 0; i < out_log.size(); i++) begin
            chk("t6_out_data", out_log[i], line_data(42'h600 + 42'(i)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
